// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and sizing helpers for conv_layer_sequencer
package systolic_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_COMPUTE,
      S_DRAIN,
      S_DONE
   } seq_state_t;

   // Weight words the weight address controller issues per filter.
   function automatic int wgt_beat_count(int kernel_size, int no_channel);
      return kernel_size * kernel_size * no_channel;
   endfunction

   // Index width never drops below one bit so single-filter/single-tile builds stay legal.
   function automatic int idx_width(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// rtl/conv_layer_sequencer_if.sv - control handshake between the layer sequencer and its address controllers
interface conv_layer_sequencer_if
   import systolic_pkg::*;
#(
   parameter int NO_FILTER = 16,
   parameter int NO_TILE   = 4
);
   localparam int FILTER_W = idx_width(NO_FILTER);
   localparam int TILE_W   = idx_width(NO_TILE);

   logic                start;
   logic                wgt_addr_valid;
   logic                ifm_last;
   logic                wgt_load;
   logic                ifm_load;
   logic                pe_en;
   logic [FILTER_W-1:0] filter_idx;
   logic [TILE_W-1:0]   tile_idx;
   logic                busy;
   logic                done;

   modport master (
      output start, wgt_addr_valid, ifm_last,
      input  wgt_load, ifm_load, pe_en, filter_idx, tile_idx, busy, done
   );

   modport slave (
      input  start, wgt_addr_valid, ifm_last,
      output wgt_load, ifm_load, pe_en, filter_idx, tile_idx, busy, done
   );
endinterface

// File: rtl/seq_counter.sv
// rtl/seq_counter.sv - up counter with clear/load/enable and a terminal-count flag
module seq_counter #(
   parameter int WIDTH    = 4,
   parameter int TERMINAL = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= count + WIDTH'(1);
      end
   end

   assign tc = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/conv_layer_sequencer.sv
// rtl/conv_layer_sequencer.sv - per-layer filter/tile sequencer for the systolic array
// Optional busy-cycle counter output cycle_cnt is built when CONV_SEQ_PERF_CNT_EN is defined.
module conv_layer_sequencer
   import systolic_pkg::*;
#(
   parameter int KERNEL_SIZE  = 3,
   parameter int NO_CHANNEL   = 3,
   parameter int NO_FILTER    = 16,
   parameter int NO_TILE      = 4,
   parameter int DRAIN_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef CONV_SEQ_PERF_CNT_EN
   output logic [31:0]          cycle_cnt,
`endif
   conv_layer_sequencer_if.slave bus
);

   localparam int BEATS    = wgt_beat_count(KERNEL_SIZE, NO_CHANNEL);
   localparam int BEAT_W   = $clog2(BEATS) + 1;
   localparam int DRAIN_W  = $clog2(DRAIN_CYCLES) + 1;
   localparam int FILTER_W = idx_width(NO_FILTER);
   localparam int TILE_W   = idx_width(NO_TILE);

   seq_state_t state;
   logic wgt_load_q, ifm_load_q, pe_en_q, busy_q, done_q;

   logic [BEAT_W-1:0]   beat_cnt;
   logic [DRAIN_W-1:0]  drain_cnt;
   logic [TILE_W-1:0]   tile_cnt;
   logic [FILTER_W-1:0] filter_cnt;
   logic beat_tc, drain_tc, tile_tc, filter_tc;

   logic start_acc, last_beat, enter_drain, drain_end, next_filter;

   assign start_acc   = (state == S_IDLE) && bus.start;
   assign last_beat   = (state == S_LOAD_W) && bus.wgt_addr_valid && beat_tc;
   assign enter_drain = (state == S_COMPUTE) && bus.ifm_last;
   assign drain_end   = (state == S_DRAIN) && drain_tc;
   assign next_filter = drain_end && tile_tc;

   // Beat counter is cleared whenever LOAD_W is entered, so a count of BEATS-1 plus a valid is the last word.
   seq_counter #(.WIDTH(BEAT_W), .TERMINAL(BEATS - 1)) u_beat_cnt (
      .clk(clk), .rst(rst), .clr(start_acc || next_filter), .load(1'b0), .load_val('0),
      .en((state == S_LOAD_W) && bus.wgt_addr_valid && !beat_tc),
      .count(beat_cnt), .tc(beat_tc)
   );

   seq_counter #(.WIDTH(DRAIN_W), .TERMINAL(DRAIN_CYCLES - 1)) u_drain_cnt (
      .clk(clk), .rst(rst), .clr(enter_drain), .load(1'b0), .load_val('0),
      .en((state == S_DRAIN) && !drain_tc),
      .count(drain_cnt), .tc(drain_tc)
   );

   seq_counter #(.WIDTH(TILE_W), .TERMINAL(NO_TILE - 1)) u_tile_cnt (
      .clk(clk), .rst(rst), .clr(start_acc || (next_filter && !filter_tc)), .load(1'b0),
      .load_val('0), .en(drain_end && !tile_tc),
      .count(tile_cnt), .tc(tile_tc)
   );

   seq_counter #(.WIDTH(FILTER_W), .TERMINAL(NO_FILTER - 1)) u_filter_cnt (
      .clk(clk), .rst(rst), .clr(start_acc), .load(1'b0), .load_val('0),
      .en(next_filter && !filter_tc),
      .count(filter_cnt), .tc(filter_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         wgt_load_q <= 1'b0;
         ifm_load_q <= 1'b0;
         pe_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state      <= S_LOAD_W;
                  wgt_load_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            S_LOAD_W: begin
               if (last_beat) begin
                  state      <= S_COMPUTE;
                  wgt_load_q <= 1'b0;
                  ifm_load_q <= 1'b1;
                  pe_en_q    <= 1'b1;
               end
            end
            S_COMPUTE: begin
               if (bus.ifm_last) begin
                  state      <= S_DRAIN;
                  ifm_load_q <= 1'b0;
               end
            end
            S_DRAIN: begin
               // Next tile of the same filter reuses the loaded weights, so pe_en stays high.
               if (drain_tc) begin
                  if (!tile_tc) begin
                     state      <= S_COMPUTE;
                     ifm_load_q <= 1'b1;
                  end else if (!filter_tc) begin
                     state      <= S_LOAD_W;
                     wgt_load_q <= 1'b1;
                     pe_en_q    <= 1'b0;
                  end else begin
                     state   <= S_DONE;
                     pe_en_q <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef CONV_SEQ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         cycle_cnt <= '0;
      end else if (busy_q && (cycle_cnt != '1)) begin
         cycle_cnt <= cycle_cnt + 32'd1;
      end
   end
`endif

   assign bus.wgt_load   = wgt_load_q;
   assign bus.ifm_load   = ifm_load_q;
   assign bus.pe_en      = pe_en_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.filter_idx = filter_cnt;
   assign bus.tile_idx   = tile_cnt;

endmodule
